// File: rtl/execute_sequencer.sv
// execute_sequencer: multi-cycle execute-stage controller (operand latch, ALU op, result/flag latch, writeback).
// Optional feature macro EXEC_PERF_CNT_EN adds the perfOps/perfBusy counters; otherwise those ports are tied to 0.
module execute_sequencer #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        issueValid,
  output logic        issueReady,
  input  logic [4:0]  opcode,
  input  logic        flush,
  output logic        ldOperands,
  output logic [12:0] aluOp,
  output logic        ldResult,
  output logic        wrFlag,
  output logic        wbValid,
  input  logic        wbReady,
  output logic        illegalOp,
  output logic        busy,
  output logic [31:0] perfOps,
  output logic [31:0] perfBusy
);

  // state | meaning
  // IDLE  | waiting for decode; accepts, drops or flags one instruction
  // OPLD  | ldOperands pulse, latency counter loaded
  // EXEC  | aluOp driven until the counter reaches terminal count
  // RES   | ldResult pulse (plus wrFlag for cmp)
  // WB    | wbValid held until the register file takes it
  typedef enum logic [2:0] {IDLE, OPLD, EXEC, RES, WB} stateT;

  localparam int MulLat = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int DivLat = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;
  localparam int MaxLat = (MulLat > DivLat) ? MulLat : DivLat;
  localparam int CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  localparam logic [3:0] OpMul = 4'd2;
  localparam logic [3:0] OpDiv = 4'd3;
  localparam logic [3:0] OpMod = 4'd4;
  localparam logic [3:0] OpCmp = 4'd5;
  localparam logic [4:0] LastAluOp  = 5'd12;
  localparam logic [4:0] LastDropOp = 5'd20;

  stateT           state, stateNext;
  logic [3:0]      opQ, opNext;
  logic [CntW-1:0] cnt, cntNext;
  logic            readyQ;
  logic            illegalQ, illegalNext;
  logic            accept;

  // readyQ keeps issueReady low while in reset and until the first clock after release
  assign issueReady = (state == IDLE) & readyQ & ~flush;
  assign accept     = issueValid & issueReady;
  assign illegalOp  = illegalQ;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      opQ      <= '0;
      cnt      <= '0;
      readyQ   <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      state    <= stateNext;
      opQ      <= opNext;
      cnt      <= cntNext;
      readyQ   <= 1'b1;
      illegalQ <= illegalNext;
    end
  end

  always_comb begin
    stateNext   = state;
    opNext      = opQ;
    cntNext     = cnt;
    illegalNext = 1'b0;
    ldOperands  = 1'b0;
    aluOp       = '0;
    ldResult    = 1'b0;
    wrFlag      = 1'b0;
    wbValid     = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (opcode <= LastAluOp) begin
            opNext    = opcode[3:0];
            stateNext = OPLD;
          end else if (opcode > LastDropOp) begin
            illegalNext = 1'b1;
          end
        end
      end
      OPLD: begin
        ldOperands = 1'b1;
        if (opQ == OpMul)                       cntNext = CntW'(MulLat - 1);
        else if (opQ == OpDiv || opQ == OpMod)  cntNext = CntW'(DivLat - 1);
        else                                    cntNext = '0;
        stateNext = EXEC;
      end
      EXEC: begin
        aluOp = 13'd1 << opQ;
        if (cnt == '0) stateNext = RES;
        else           cntNext   = cnt - CntW'(1);
      end
      RES: begin
        ldResult  = 1'b1;
        wrFlag    = (opQ == OpCmp);
        stateNext = (opQ == OpCmp) ? IDLE : WB;
      end
      WB: begin
        wbValid = 1'b1;
        if (wbReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // flush outranks everything, including a writeback handshake in the same cycle
    if (flush) stateNext = IDLE;
  end

`ifdef EXEC_PERF_CNT_EN
  logic [31:0] perfOpsQ, perfBusyQ;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      perfOpsQ  <= '0;
      perfBusyQ <= '0;
    end else begin
      if (state == RES)  perfOpsQ  <= perfOpsQ + 32'd1;
      if (state != IDLE) perfBusyQ <= perfBusyQ + 32'd1;
    end
  end

  assign perfOps  = perfOpsQ;
  assign perfBusy = perfBusyQ;
`else
  assign perfOps  = '0;
  assign perfBusy = '0;
`endif

endmodule

// File: tb/tb_execute_sequencer.sv
// Directed bench for execute_sequencer; expected strobes come from the cycle-latency table (accept = cycle 0).
module tb_execute_sequencer;
  localparam int MulC = 3;
  localparam int DivC = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        issueValid, issueReady, flush, wbReady;
  logic [4:0]  opcode;
  logic        ldOperands, ldResult, wrFlag, wbValid, illegalOp, busy;
  logic [12:0] aluOp;
  logic [31:0] perfOps, perfBusy;

  int checks = 0;
  int failures = 0;

  execute_sequencer #(.MUL_CYCLES(MulC), .DIV_CYCLES(DivC)) dut (
    .clk(clk), .rstN(rstN), .issueValid(issueValid), .issueReady(issueReady),
    .opcode(opcode), .flush(flush), .ldOperands(ldOperands), .aluOp(aluOp),
    .ldResult(ldResult), .wrFlag(wrFlag), .wbValid(wbValid), .wbReady(wbReady),
    .illegalOp(illegalOp), .busy(busy), .perfOps(perfOps), .perfBusy(perfBusy)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag, input logic expRdy);
    checkEq({tag, "_rdy"},   issueReady, expRdy);
    checkEq({tag, "_ldop"},  ldOperands, 0);
    checkEq({tag, "_alu"},   aluOp, 0);
    checkEq({tag, "_ldres"}, ldResult, 0);
    checkEq({tag, "_wrf"},   wrFlag, 0);
    checkEq({tag, "_wb"},    wbValid, 0);
    checkEq({tag, "_ill"},   illegalOp, 0);
    checkEq({tag, "_busy"},  busy, 0);
  endtask

  // Entered at posedge+1 with the DUT idle; issues op in cycle 0 and checks cycles 0..nCyc-1.
  task automatic runOp(input string nm, input int op, input int nCyc,
                       input int stFrom, input int stTo, input int flushAt);
    int lat, eRes, wbEnd, endC;
    bit isCmp, legal, live, eBusy;
    logic [12:0] eAlu;
    string t;
    lat   = (op == 2) ? MulC : ((op == 3 || op == 4) ? DivC : 1);
    isCmp = (op == 5);
    legal = (op <= 12);
    eRes  = 2 + lat;
    wbEnd = 3 + lat;
    while (wbEnd >= stFrom && wbEnd <= stTo) wbEnd++;
    endC  = isCmp ? eRes : wbEnd;
    for (int c = 0; c < nCyc; c++) begin
      issueValid = (c == 0);
      opcode     = 5'(op);
      wbReady    = !(c >= stFrom && c <= stTo);
      flush      = (c == flushAt);
      #1;
      t     = $sformatf("%s_c%0d", nm, c);
      live  = legal && flushAt != 0 && (flushAt < 0 || c <= flushAt);
      eBusy = live && c >= 1 && c <= endC;
      eAlu  = (live && c >= 2 && c <= 1 + lat) ? (13'd1 << op) : 13'd0;
      checkEq({t, "_ldop"},  ldOperands, live && c == 1);
      checkEq({t, "_alu"},   aluOp, eAlu);
      checkEq({t, "_ldres"}, ldResult, live && c == eRes);
      checkEq({t, "_wrf"},   wrFlag, live && isCmp && c == eRes);
      checkEq({t, "_wb"},    wbValid, live && !isCmp && c >= 3 + lat && c <= wbEnd);
      checkEq({t, "_busy"},  busy, eBusy);
      checkEq({t, "_rdy"},   issueReady, !eBusy && c != flushAt);
      checkEq({t, "_ill"},   illegalOp, op >= 21 && flushAt != 0 && c == 1);
      @(posedge clk);
      #1;
    end
    issueValid = 1'b0;
    flush      = 1'b0;
    wbReady    = 1'b1;
  endtask

  initial begin
    rstN = 1'b0; issueValid = 1'b0; opcode = '0; flush = 1'b0; wbReady = 1'b1;
    #1;
    checkIdleOutputs("rst", 1'b0);
    checkEq("rst_perfOps", perfOps, 0);
    #11 rstN = 1'b1;
    #1 checkEq("rel_rdy_before_clk", issueReady, 0);
    @(posedge clk); #1;
    checkIdleOutputs("rel", 1'b1);

    runOp("add",      0,  7, 100, -1, -1);
    runOp("mul",      2,  8, 100, -1, -1);
    runOp("div",      3, 13, 100, -1, -1);
    runOp("mod",      4, 13, 100, -1, -1);
    runOp("cmp",      5,  6, 100, -1, -1);
    runOp("lsl",     10,  7, 100, -1, -1);
    runOp("asr",     12,  7, 100, -1, -1);
    runOp("addStall", 0, 10,   4,  7, -1);
    runOp("divFlush", 3,  8, 100, -1,  5);
    runOp("wbFlush",  0,  8,   4,  6,  5);
    runOp("wbFlushRdy", 0, 7, 100, -1, 4);
    runOp("ill25",   25,  4, 100, -1, -1);
    runOp("drop16",  16,  4, 100, -1, -1);
    runOp("ill31Fl", 31,  3, 100, -1,  0);
    runOp("addFl0",   0,  3, 100, -1,  0);
    runOp("mov",      9,  7, 100, -1, -1);

    // Partial mul (cycles 0..3), then reset during EXEC cycle 4.
    runOp("mulRst",   2,  4, 100, -1, -1);
    checkEq("mulRst_c4_alu_pre", aluOp, 13'h0004);
    rstN = 1'b0;
    #1;
    checkIdleOutputs("midRst", 1'b0);
    #3 rstN = 1'b1;
    #1 checkEq("midRst_rdy_before_clk", issueReady, 0);
    @(posedge clk); #1;
    checkIdleOutputs("postRst", 1'b1);

    // Three adds, each with one stalled writeback cycle: 5 busy cycles apiece.
    runOp("perfA", 0, 7, 4, 4, -1);
    runOp("perfB", 0, 7, 4, 4, -1);
    runOp("perfC", 0, 7, 4, 4, -1);
`ifdef EXEC_PERF_CNT_EN
    checkEq("perfOps",  perfOps, 3);
    checkEq("perfBusy", perfBusy, 15);
`else
    checkEq("perfOps_tied",  perfOps, 0);
    checkEq("perfBusy_tied", perfBusy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/execute_sequencer.md
Name: execute_sequencer

Overview:
Multi-cycle controller for the execute stage: accepts one decoded instruction at a time from decode, sequences operand latch, ALU operation, result/flag latch and register-file writeback. Variable ALU latency: 1 cycle for simple ops, parameterised for mul and div/mod. Drives the ALU load/select strobes and back-pressures fetch/decode through issueReady.

Parameters:
MUL_CYCLES, 3, EXEC cycles for mul (opcode 2); 0 treated as 1
DIV_CYCLES, 8, EXEC cycles for div/mod (opcodes 3,4); 0 treated as 1

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
issueValid  in  1  decode presents an instruction
issueReady  out  1  sequencer accepts; equals (state==IDLE) & !flush
opcode  in  5  instruction opcode, sampled on accept
flush  in  1  synchronous abort, e.g. branch taken
ldOperands  out  1  one-cycle pulse; ALU latches A/B
aluOp  out  13  one-hot; bit i = opcode i (0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr); nonzero only in EXEC
ldResult  out  1  one-cycle pulse; ALU result register load
wrFlag  out  1  one-cycle pulse for cmp only, coincident with ldResult
wbValid  out  1  writeback request to register file
wbReady  in  1  register file accepts writeback
illegalOp  out  1  one-cycle pulse when opcode 21..31 accepted
busy  out  1  state != IDLE

Behaviour:
- Reset (rstN=0, async): state IDLE, latched opcode 0, counter 0; all outputs 0, including issueReady while rstN low. issueReady=1 from the first clk after release.
- States: IDLE, OPLD, EXEC, RES, WB. One instruction in flight. Accept only in IDLE.
- IDLE: on issueValid & issueReady: opcode 0..12 -> latch opcode, go OPLD. Opcode 13..20 (nop, ld, st, branches, call, ret): accepted and dropped, stay IDLE. Opcode 21..31: accepted, illegalOp=1 next cycle, stay IDLE.
- OPLD: ldOperands=1; load counter with latency-1 (mul MUL_CYCLES-1, div/mod DIV_CYCLES-1, else 0); go EXEC.
- EXEC: aluOp held at one-hot of latched opcode; counter==0 -> RES, else decrement.
- RES: ldResult=1; cmp: wrFlag=1, go IDLE (no writeback); others -> WB.
- WB: wbValid held 1 until wbValid & wbReady, then IDLE. wbReady low indefinitely holds WB; no timeout.
- Latency from accept edge (cycle 0): ldOperands cycle 1, EXEC cycles 2..(1+L), ldResult 2+L, wbValid from 3+L. Add: issueReady again cycle 5 at earliest.
- Counter width sized for max(MUL_CYCLES, DIV_CYCLES); no wrap.
- flush: any state -> IDLE next edge; all pulses deasserted that edge; in-flight op discarded. Flush in WB with wbReady=1 the same cycle: flush wins, wbValid is still seen high that cycle (commit belongs to the register file), no further strobes. Flush with issueValid in IDLE: not accepted.
- Reset mid-operation: immediate return to reset values, no partial strobes.

Optional Feature:
EXEC_PERF_CNT_EN: when defined, adds outputs perfOps (32, increments on each RES cycle) and perfBusy (32, increments each cycle busy=1). Both wrap 0xFFFFFFFF -> 0 and are cleared only by rstN. When undefined, the ports exist, are tied to 0 and have no registers.

Test Plan:
- add (opcode 0) accepted at cycle 0, wbReady=1 -> ldOperands@1, aluOp=13'h0001@2, ldResult@3, wbValid@4, issueReady=1@5.
- mul, MUL_CYCLES=3 -> aluOp=13'h0004 on cycles 2-4, ldResult@5, wbValid@6; div, DIV_CYCLES=8 -> aluOp=13'h0008 cycles 2-9, ldResult@10.
- cmp (opcode 5) -> ldResult and wrFlag both @3, wbValid never asserted, issueReady=1@4.
- add with wbReady low cycles 4-7, high @8 -> wbValid 1 cycles 4-8, IDLE@9, busy low @9.
- div, flush @5 -> IDLE @6, no ldResult/wbValid; opcode 25 issued -> illegalOp one pulse, busy stays 0; opcode 16 -> silently dropped.
- rstN low mid-EXEC of mul -> all outputs 0 immediately; with EXEC_PERF_CNT_EN, after 3 adds perfOps=3 and perfBusy=15.
